// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: Wishbone register port plus the SPI pins.
`timescale 1ns/1ps
interface spi_slave_if;
  logic        wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        sclk_i;
  logic        ss_n_i;
  logic        mosi_i;
  logic        miso_o;
  logic        miso_oe_o;
  logic        irq_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  sclk_i, ss_n_i, mosi_i,
    output wb_dat_o, wb_ack_o, miso_o, miso_oe_o, irq_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output sclk_i, ss_n_i, mosi_i,
    input  wb_dat_o, wb_ack_o, miso_o, miso_oe_o, irq_o
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI responder with a 16-bit Wishbone register port; ack one cycle after strobe, never stalls.
// SPI pins are synchronized (SYNC_STAGES flops) so an edge takes effect SYNC_STAGES+1 cycles later.
`timescale 1ns/1ps
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input logic        wb_clk_i,
  input logic        wb_rst_i,
  spi_slave_if.slave bus
);

  logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe;
  logic sclk_prev, ss_prev;
  logic sclk_s, ss_s, mosi_s;
  logic selected, ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic byte_done, tx_load, tx_shift_en;

  logic [2:0] bit_cnt;
  logic       bit_seen;
  logic [7:0] rx_shift, tx_shift, rx_data, tx_hold;
  logic       rx_valid, overrun, underrun, tx_full, ien;
  logic       miso_oe, ack, irq;
  logic       acc, rd_data, wr_data, wr_ctrl;
  logic [15:0] status, dat_out;
  logic       unused_dat;

  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign ss_s   = ss_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sclk_pipe <= '0;
      ss_pipe   <= '1;
      mosi_pipe <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], bus.sclk_i};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], bus.ss_n_i};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.mosi_i};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign selected    = ~ss_s;
  assign ss_fall     = ss_prev & ~ss_s;
  assign ss_rise     = ~ss_prev & ss_s;
  assign sclk_rise   = selected & sclk_s & ~sclk_prev;
  assign sclk_fall   = selected & ~sclk_s & sclk_prev;
  assign byte_done   = sclk_rise & (bit_cnt == 3'd7);
  // bit_seen keeps a falling edge right after select from counting as a byte boundary
  assign tx_load     = ss_fall | (sclk_fall & (bit_cnt == 3'd0) & bit_seen);
  assign tx_shift_en = sclk_fall & (bit_cnt != 3'd0);

  assign acc     = ack & bus.wb_cyc_i & bus.wb_stb_i;
  assign rd_data = acc & ~bus.wb_we_i & ~bus.wb_adr_i;
  assign wr_data = acc & bus.wb_we_i & ~bus.wb_adr_i & bus.wb_sel_i[0];
  assign wr_ctrl = acc & bus.wb_we_i & bus.wb_adr_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt  <= 3'd0;
      bit_seen <= 1'b0;
      rx_shift <= 8'h00;
      tx_shift <= IDLE_BYTE;
      miso_oe  <= 1'b0;
    end else if (ss_rise) begin
      bit_cnt  <= 3'd0;
      bit_seen <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      if (ss_fall) begin
        bit_cnt  <= 3'd0;
        bit_seen <= 1'b0;
        miso_oe  <= 1'b1;
      end
      if (sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        bit_seen <= 1'b1;
      end
      if (tx_load)
        tx_shift <= tx_full ? tx_hold : IDLE_BYTE;
      else if (tx_shift_en)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // Set conditions are tested first so a coincident clear loses.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      tx_hold  <= IDLE_BYTE;
      tx_full  <= 1'b0;
      ien      <= 1'b0;
      ack      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ack <= bus.wb_cyc_i & bus.wb_stb_i & ~ack;
      irq <= ien & (rx_valid | overrun | underrun);
      if (byte_done)
        rx_data <= {rx_shift[6:0], mosi_s};
      if (byte_done)
        rx_valid <= 1'b1;
      else if (rd_data)
        rx_valid <= 1'b0;
      if (byte_done & rx_valid & ~rd_data)
        overrun <= 1'b1;
      else if (wr_ctrl & bus.wb_sel_i[0] & bus.wb_dat_i[2])
        overrun <= 1'b0;
      if (tx_load & ~tx_full)
        underrun <= 1'b1;
      else if (wr_ctrl & bus.wb_sel_i[0] & bus.wb_dat_i[4])
        underrun <= 1'b0;
      if (wr_data)
        tx_hold <= bus.wb_dat_i[7:0];
      if (wr_data)
        tx_full <= 1'b1;
      else if (tx_load)
        tx_full <= 1'b0;
      if (wr_ctrl & bus.wb_sel_i[1])
        ien <= bus.wb_dat_i[8];
    end
  end

  assign status = {7'b0, ien, 3'b0, underrun, ~ss_s, overrun, tx_full, rx_valid};

  always_comb begin
    dat_out = 16'h0000;
    if (ack)
      dat_out = bus.wb_adr_i ? status : {8'h00, rx_data};
  end

  assign unused_dat    = &{1'b0, bus.wb_dat_i[15:9]};
  assign bus.wb_dat_o  = dat_out;
  assign bus.wb_ack_o  = ack;
  assign bus.miso_oe_o = miso_oe;
  assign bus.miso_o    = miso_oe ? tx_shift[7] : 1'b1;
  assign bus.irq_o     = irq;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: randomized SPI/Wishbone traffic against a transaction-level model, scoreboarded.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst;
  always #40 clk = ~clk;

  spi_slave_if bus();
  spi_slave dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [15:0] rd_q[$];
  logic [7:0]  miso_q[$];
  logic [7:0]  spi_buf[4];

  logic [7:0] m_rx_data, m_tx_hold;
  bit m_rx_valid, m_ovr, m_udr, m_tx_full, m_ien, m_busy;

  function automatic logic [15:0] m_status();
    return {7'b0, m_ien, 3'b0, m_udr, m_busy, m_ovr, m_tx_full, m_rx_valid};
  endfunction

  function automatic void m_reset();
    m_rx_data = 8'h00; m_tx_hold = 8'hFF;
    m_rx_valid = 0; m_ovr = 0; m_udr = 0; m_tx_full = 0; m_ien = 0; m_busy = 0;
  endfunction

  // Byte the responder will start shifting at select or a byte boundary.
  function automatic logic [7:0] m_load();
    if (m_tx_full) begin
      m_tx_full = 0;
      return m_tx_hold;
    end
    m_udr = 1;
    return 8'hFF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  logic ack_d = 1'b0;
  always @(negedge clk) begin
    if (bus.wb_ack_o) begin
      check("ack_single_cycle", ack_d, 0);
      if (!bus.wb_we_i) begin
        check("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rd_data", bus.wb_dat_o, rd_q.pop_front());
      end
    end
    ack_d = bus.wb_ack_o;
  end

  int mb_cnt = 0;
  logic [7:0] mb_sh = 8'h00;
  always @(posedge bus.sclk_i or negedge bus.ss_n_i) begin
    if (bus.sclk_i && !bus.ss_n_i) begin
      mb_sh = {mb_sh[6:0], bus.miso_o};
      mb_cnt++;
      if (mb_cnt == 8) begin
        mb_cnt = 0;
        check("miso_oe", bus.miso_oe_o, 1);
        check("miso_expected", miso_q.size() != 0, 1);
        if (miso_q.size() != 0) check("miso_byte", mb_sh, miso_q.pop_front());
      end
    end else if (!bus.sclk_i) begin
      mb_cnt = 0;
    end
  end

  task automatic wb_cycle(input bit we, input bit adr, input logic [15:0] dat,
                          input logic [1:0] sel, input bit hold);
    int n;
    if (!we) begin
      rd_q.push_back(adr ? m_status() : {8'h00, m_rx_data});
      if (!adr) m_rx_valid = 0;
    end else if (!adr) begin
      if (sel[0]) begin m_tx_hold = dat[7:0]; m_tx_full = 1; end
    end else begin
      if (sel[1]) m_ien = dat[8];
      if (sel[0] && dat[2]) m_ovr = 0;
      if (sel[0] && dat[4]) m_udr = 0;
    end
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.wb_ack_o && n < 16);
    check("ack_seen", bus.wb_ack_o, 1);
    @(posedge clk); #1;
    if (!hold) begin bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; end
  endtask

  // Sends spi_buf[0..nbytes-1]; the last byte is cut to lastbits bits.
  // coincide issues a DATA read timed to land on the final byte's completion.
  task automatic spi_xfer(input int nbytes, input int lastbits, input bit coincide);
    logic [7:0] b;
    int nb;
    bus.ss_n_i = 0; m_busy = 1;
    b = m_load();
    if (nbytes > 1 || lastbits == 8) miso_q.push_back(b);
    for (int i = 0; i < nbytes; i++) begin
      nb = (i == nbytes - 1) ? lastbits : 8;
      for (int k = 0; k < nb; k++) begin
        bus.mosi_i = spi_buf[i][7-k];
        repeat (H) @(negedge clk);
        bus.sclk_i = 1;
        if (coincide && i == nbytes - 1 && k == 7) begin
          @(negedge clk);
          fork wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0); join_none
          repeat (H - 1) @(negedge clk);
        end else begin
          repeat (H) @(negedge clk);
        end
        bus.sclk_i = 0;
      end
      if (nb == 8) begin
        if (m_rx_valid) m_ovr = 1;
        m_rx_valid = 1;
        m_rx_data  = spi_buf[i];
        b = m_load();
        if (i + 1 < nbytes && (i + 1 < nbytes - 1 || lastbits == 8)) miso_q.push_back(b);
      end
    end
    repeat (H) @(negedge clk);
    bus.ss_n_i = 1; m_busy = 0; bus.mosi_i = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_irq();
    repeat (3) @(negedge clk);
    check("irq_level", bus.irq_o, m_ien & (m_rx_valid | m_ovr | m_udr));
  endtask

  initial begin
    #(80 * 60000);
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst = 1;
    bus.ss_n_i = 1; bus.sclk_i = 0; bus.mosi_i = 0;
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = 0; bus.wb_dat_i = 16'h0000; bus.wb_sel_i = 2'b00;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_miso_oe", bus.miso_oe_o, 0);
    check("rst_miso", bus.miso_o, 1);
    check("rst_irq", bus.irq_o, 0);
    check("rst_ack", bus.wb_ack_o, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    rst = 0;
    repeat (4) @(negedge clk);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);

    // Queued TX byte goes out while a byte comes in.
    wb_cycle(1'b1, 1'b0, 16'h00A5, 2'b01, 1'b0);
    spi_buf[0] = 8'h3C; spi_xfer(1, 8, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    check_irq();

    // Two bytes without a read: overrun, then clear it.
    wb_cycle(1'b1, 1'b1, 16'h0014, 2'b01, 1'b0);
    spi_buf[0] = 8'h11; spi_buf[1] = 8'h22; spi_xfer(2, 8, 1'b0);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b1, 1'b1, 16'h0004, 2'b01, 1'b0);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);

    // Empty TX at select: idle byte, underrun, irq one cycle after it.
    wb_cycle(1'b1, 1'b1, 16'h0114, 2'b11, 1'b0);
    fork
      begin
        int n;
        n = 0;
        @(negedge bus.ss_n_i);
        while (!bus.irq_o && n < 20) begin @(negedge clk); n++; end
        check("irq_latency_cycles", n, 4);
      end
      begin
        @(negedge clk);
        spi_buf[0] = 8'h5E; spi_xfer(1, 8, 1'b0);
      end
    join
    check_irq();
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b1, 1'b1, 16'h0014, 2'b01, 1'b0);
    check_irq();

    // Deselect mid-byte, then a clean byte.
    spi_buf[0] = 8'hF0; spi_xfer(1, 5, 1'b0);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    spi_buf[0] = 8'h81; spi_xfer(1, 8, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);

    // Back-to-back strobes, then a DATA read on the completion cycle.
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b1);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b1, 1'b1, 16'h0014, 2'b01, 1'b0);
    spi_buf[0] = 8'h5A; spi_xfer(1, 8, 1'b0);
    spi_buf[0] = 8'hC3; spi_xfer(1, 8, 1'b1);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);

    // Reset in the middle of a byte.
    wb_cycle(1'b1, 1'b0, 16'h0077, 2'b01, 1'b0);
    bus.ss_n_i = 0;
    for (int k = 0; k < 3; k++) begin
      bus.mosi_i = 1;
      repeat (H) @(negedge clk);
      bus.sclk_i = 1;
      repeat (H) @(negedge clk);
      bus.sclk_i = 0;
    end
    rst = 1;
    @(negedge clk);
    check("midrst_miso_oe", bus.miso_oe_o, 0);
    check("midrst_miso", bus.miso_o, 1);
    check("midrst_irq", bus.irq_o, 0);
    check("midrst_ack", bus.wb_ack_o, 0);
    bus.ss_n_i = 1; bus.mosi_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_reset();
    repeat (4) @(negedge clk);
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
    wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: wb_cycle(1'b1, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), 1'b0);
        1: wb_cycle(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0);
        2: wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);
        3: wb_cycle(1'b1, 1'b1, 16'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)), 1'b0);
        default: begin
          int nb, lb;
          nb = $urandom_range(1, 3);
          lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
          for (int j = 0; j < 4; j++) spi_buf[j] = 8'($urandom_range(0, 255));
          spi_xfer(nb, lb, 1'b0);
        end
      endcase
      check_irq();
    end
    wb_cycle(1'b0, 1'b1, 16'h0000, 2'b11, 1'b0);

    repeat (10) @(negedge clk);
    check("rd_q_drained", rd_q.size(), 0);
    check("miso_q_drained", miso_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Wishbone-attached SPI slave (responder): the far end of the team's SPI master bus.
- A host or test master drives sclk/mosi/ss_n. This block shifts bytes in and out and exposes them to the CPU through a 16-bit Wishbone register port clocked by the 12.5 MHz system clock.
- Used for board-to-board links and for loopback-testing the SPI master in the SoC.

Parameters:
- IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is queued at a byte boundary.
- SYNC_STAGES, 2, synchronizer depth on sclk_i, ss_n_i, mosi_i (minimum 2).

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wb_adr_i  in  1  word address: 0 = DATA, 1 = STATUS/CTRL.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_sel_i  in  2  byte lanes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- sclk_i  in  1  SPI clock from master, asynchronous.
- ss_n_i  in  1  slave select, active low, asynchronous.
- mosi_i  in  1  master-out data, asynchronous.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  MISO output enable; high only while selected.
- irq_o  out  1  interrupt request, level.

Behaviour:
- **Reset (asynchronous):** all outputs 0 except miso_o=1. rx_data=0; all flags 0; tx_hold=IDLE_BYTE; bit counter 0; interrupt enable 0.
- **Synchronization:** sclk_i, ss_n_i, mosi_i pass through SYNC_STAGES flops. Edges are detected on the synchronized copies. sclk_i frequency must be ≤ wb_clk_i/8.
- **SPI mode:** mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Multiple bytes may be sent per ss_n low period.
- **Select (ss_n falling edge):**
  - bit counter=0; miso_oe_o=1.
  - tx_shift loads tx_hold if tx_full (tx_full cleared); otherwise loads IDLE_BYTE and sets underrun.
  - miso_o = tx_shift[7].
- **sclk rising edge while selected:** rx_shift={rx_shift[6:0],mosi}; counter++.
  - On the 8th bit (counter wraps 7→0): rx_data={rx_shift[6:0],mosi}.
  - If rx_valid is already set and not being cleared this cycle, set overrun (the new byte overwrites). Set rx_valid.
- **sclk falling edge while selected:**
  - counter≠0: tx_shift shifts left.
  - counter==0 (byte boundary, not the first falling edge after select): reload tx_shift from tx_hold or IDLE_BYTE, using the same rules as select.
  - miso_o follows tx_shift[7].
- **Deselect (ss_n rising edge):** a partial byte is discarded, counter=0, miso_oe_o=0, miso_o=1. Rising/falling sclk edges are ignored while deselected.
- **Wishbone:**
  - wb_ack_o is registered: it asserts exactly one cycle after cyc&stb&~ack and lasts one cycle. No wait states beyond that, no error.
  - Side effects occur on the acked cycle.
  - Reads return data when ack is high.
- **DATA (adr 0):**
  - Read returns {8'h00, rx_data} and clears rx_valid.
  - Write with sel[0] loads tx_hold=dat[7:0] and sets tx_full. A write while tx_full overwrites silently.
- **STATUS (adr 1):**
  - Read = {7'b0, ien, 3'b0, underrun, busy(~ss_sync), overrun, tx_full, rx_valid} (bit8=ien, bit4=underrun, bit3=busy, bit2=overrun, bit1=tx_full, bit0=rx_valid).
  - Write: sel[1] & dat[8] → ien; sel[0] & dat[2]=1 clears overrun; sel[0] & dat[4]=1 clears underrun.
- **Simultaneous events:**
  - Byte completes in the same cycle as a DATA read: rx_valid stays 1 with the new byte; no overrun.
  - DATA write in the same cycle as a tx load: the load takes the old tx_hold; the write then refills it and tx_full=1.
  - Flag set and clear in the same cycle: set wins.
- **Interrupt:** irq_o = ien & (rx_valid | overrun | underrun), registered (1-cycle latency).

Test Plan:
- Reset: assert wb_rst_i mid-byte → all flags 0, miso_oe_o=0, miso_o=1, STATUS reads 16'h0000 (ss_n high).
- Write DATA 8'hA5, then master sends 8'h3C (one byte) → miso shows 1010_0101 MSB-first; DATA reads 16'h003C; STATUS bit0 clears after the read; tx_full=0.
- Master sends two bytes 8'h11, 8'h22 without reads → rx_data=8'h22, overrun=1; STATUS write 16'h0004 clears overrun.
- Select with empty tx_hold → miso shifts 8'hFF, underrun=1; with ien=1, irq_o rises 1 cycle after underrun sets.
- Deselect after 5 bits of 8'hF0 → rx_valid stays 0, counter reset; the next full byte 8'h81 is received correctly.
- Back-to-back Wishbone strobes → wb_ack_o pulses 1 cycle each, never two consecutive cycles for one strobe; a DATA read coincident with byte completion leaves rx_valid=1, overrun=0.
